// File: rtl/polyveck_decompose_seq.sv
// Sequential Dilithium3 vector decompose: walks K*N coefficients from RAM through one
// shared arithmetic lane and streams address-tagged (a1, a0) results through a small FIFO.
module polyveck_decompose_seq #(
  parameter int K          = 6,
  parameter int N          = 256,
  parameter int AW         = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [3:0]    out_a1,
  output logic [31:0]   out_a0
);

  localparam int            TOTAL = K * N;
  localparam logic [AW-1:0] LAST  = AW'(TOTAL - 1);
  localparam int            PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    a1;
    logic [31:0]   a0;
  } entry_t;

  state_t        state, state_d;
  logic [AW-1:0] rd_cnt, acc_cnt;
  logic          inflight;
  logic [AW-1:0] inflight_addr;

  entry_t        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          push, pop;

  // Arithmetic lane: rd_data is valid the cycle after rd_en, so it is decomposed
  // combinationally and lands in the FIFO at the end of that cycle.
  logic [31:0]        t0, prod, a0_raw;
  logic [3:0]         a1_c;
  logic signed [31:0] a0_c;

  always_comb begin
    t0     = (rd_data + 32'd127) >> 7;
    a1_c   = 4'((t0 * 32'd1025 + 32'd2097152) >> 22);
    prod   = 32'(a1_c) * 32'd523776;
    a0_raw = rd_data - prod;
    a0_c   = ($signed(a0_raw) > 32'sd4190208) ? $signed(a0_raw) - 32'sd8380417
                                              : $signed(a0_raw);
  end

  assign push      = inflight;
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;

  // Fields are forced to zero while empty so the stream is clean out of reset.
  always_comb begin
    out_addr = '0;
    out_a1   = '0;
    out_a0   = '0;
    if (out_valid) begin
      out_addr = fifo_mem[rd_ptr].addr;
      out_a1   = fifo_mem[rd_ptr].a1;
      out_a0   = fifo_mem[rd_ptr].a0;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    rd_en   = (state == RUN) && ((fifo_cnt + (PW+1)'(inflight)) < (PW+1)'(FIFO_DEPTH));
    busy    = (state == RUN) || (state == DRAIN);
    done    = (state == DONE);
    unique case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_en && rd_cnt == LAST) state_d = DRAIN;
      DRAIN:   if (pop && acc_cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr = rd_cnt;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      acc_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
    end else begin
      state         <= state_d;
      inflight      <= rd_en;
      inflight_addr <= rd_cnt;
      if (state == IDLE)  rd_cnt <= '0;
      else if (rd_en)     rd_cnt <= rd_cnt + 1'b1;
      if (state == IDLE)  acc_cnt <= '0;
      else if (pop)       acc_cnt <= acc_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: inflight_addr, a1: a1_c, a0: a0_c};
  end

endmodule

// File: tb/tb_polyveck_decompose_seq.sv
// Directed bench for polyveck_decompose_seq: coefficient RAM model, software decompose
// reference, full passes with streaming, backpressure, hold-off, stray start and abort.
module tb_polyveck_decompose_seq;

  localparam int AW    = 11;
  localparam int TOTAL = 1536;
  localparam int Q     = 8380417;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr, out_addr;
  logic [31:0]   rd_data = '0;
  logic [3:0]    out_a1;
  logic [31:0]   out_a0;

  int passed = 0;
  int total  = 0;

  logic [31:0] ram [2048];
  logic [3:0]  hand_a1 [4] = '{4'd0, 4'd0, 4'd1, 4'd0};
  logic [31:0] hand_a0 [4] = '{32'd0, 32'd261888, 32'hFFFC0101, 32'hFFFFFFFF};

  polyveck_decompose_seq #(.K(6), .N(256), .AW(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_a1(out_a1), .out_a0(out_a0)
  );

  always #5 clk = ~clk;

  // Coefficient RAM: data appears the cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [31:0] a, output logic [3:0] m1,
                                output logic [31:0] m0);
    longint hi, lo;
    hi = (longint'(a) + 127) / 128;
    hi = ((hi * 1025 + 2097152) / 4194304) % 16;
    lo = longint'(a) - hi * 523776;
    if (lo > (Q - 1) / 2) lo = lo - Q;
    m1 = 4'(hi);
    m0 = 32'(lo);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(busy), 64'd0);
    check({tag, "_rd_en"},     64'(rd_en), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_addr"},  64'(out_addr), 64'd0);
    check({tag, "_out_a1"},    64'(out_a1), 64'd0);
    check({tag, "_out_a0"},    64'(out_a0), 64'd0);
  endtask

  task automatic run_pass(input string name, input int ready_pct, input int hold_off,
                          input bit mid_start, input int abort_at, input bit timing,
                          input bit hand);
    int exp_rd = 0, exp_out = 0, done_cnt = 0;
    int first_rd = -1, first_out = -1, done_cyc = -1, last_hs = -1;
    bit prev_stall = 0, occ_bad = 0, stable_bad = 0, fired = 0, aborted = 0;
    logic [AW+35:0] prev_fields = '0;
    logic [3:0]  m1;
    logic [31:0] m0;

    @(negedge clk);
    start = 1'b1;
    out_ready = (hold_off == 0);
    @(negedge clk);
    check({name, "_busy_after_start"}, 64'(busy), 64'd1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      start = 1'b0;
      if (cyc < hold_off)       out_ready = 1'b0;
      else if (ready_pct >= 100) out_ready = 1'b1;
      else                       out_ready = ($urandom_range(99) < ready_pct);
      if (mid_start && !fired && exp_rd == 500) begin
        start = 1'b1;
        fired = 1;
      end
      if (abort_at > 0 && exp_out == abort_at) begin
        rst = 1'b1;
        aborted = 1;
        break;
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        check({name, "_rd_addr"}, 64'(rd_addr), 64'(exp_rd));
        exp_rd++;
      end
      if (exp_rd - exp_out > 4) occ_bad = 1;
      if (hold_off > 0 && cyc == hold_off - 1) begin
        check({name, "_reads_while_stalled"}, 64'(exp_rd), 64'd4);
        check({name, "_rd_en_while_stalled"}, 64'(rd_en), 64'd0);
      end
      if (prev_stall && (!out_valid || {out_addr, out_a1, out_a0} !== prev_fields))
        stable_bad = 1;
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        model(ram[exp_out], m1, m0);
        check({name, "_out_addr"}, 64'(out_addr), 64'(exp_out));
        check({name, "_out_a1"},   64'(out_a1), 64'(m1));
        check({name, "_out_a0"},   64'(out_a0), 64'(m0));
        if (hand && exp_out < 4) begin
          check({name, "_hand_a1"}, 64'(out_a1), 64'(hand_a1[exp_out]));
          check({name, "_hand_a0"}, 64'(out_a0), 64'(hand_a0[exp_out]));
        end
        exp_out++;
        last_hs = cyc;
      end
      prev_stall  = out_valid && !out_ready;
      prev_fields = {out_addr, out_a1, out_a0};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      @(negedge clk);
    end
    if (aborted) begin
      @(negedge clk);
      check_idle_outputs({name, "_after_abort"});
      rst = 1'b0;
    end else begin
      check({name, "_done_pulses"},  64'(done_cnt), 64'd1);
      check({name, "_results"},      64'(exp_out), 64'(TOTAL));
      check({name, "_reads"},        64'(exp_rd), 64'(TOTAL));
      check({name, "_occupancy_ok"}, 64'(occ_bad), 64'd0);
      check({name, "_stable_ok"},    64'(stable_bad), 64'd0);
      check({name, "_busy_after"},   64'(busy), 64'd0);
      check({name, "_done_after_hs"}, 64'(done_cyc - last_hs), 64'd1);
      if (timing) begin
        // Result i leaves at first_rd+2+i; done follows the last handshake by one cycle.
        check({name, "_first_latency"}, 64'(first_out - first_rd), 64'd2);
        check({name, "_done_latency"},  64'(done_cyc - first_rd), 64'd1538);
      end
    end
  endtask

  initial begin
    ram[0] = 32'd0;
    ram[1] = 32'd261888;
    ram[2] = 32'd261889;
    ram[3] = 32'd8380416;
    for (int i = 4; i < 2048; i++) ram[i] = 32'($urandom_range(Q - 1));
    ram[4] = 32'(Q - 1);
    ram[5] = 32'd4190208;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_done",    64'(done), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;

    run_pass("full",     100, 0,  1'b0, 0,   1'b1, 1'b1);
    run_pass("bp30",     30,  0,  1'b0, 0,   1'b0, 1'b0);
    run_pass("hold",     100, 20, 1'b0, 0,   1'b0, 1'b0);
    run_pass("midstart", 100, 0,  1'b1, 0,   1'b0, 1'b0);
    run_pass("abort",    100, 0,  1'b0, 300, 1'b0, 1'b0);
    run_pass("restart",  100, 0,  1'b0, 0,   1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
